// File: rtl/ppb_pkg.sv
// Shared constants, opcodes and state encoding for the PPB host link.
package ppb_pkg;

    localparam logic [7:0] OP_STEP  = 8'h01;
    localparam logic [7:0] OP_RUN   = 8'h02;
    localparam logic [7:0] OP_RESET = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h10;
    localparam logic [7:0] OP_SNAP  = 8'h20;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    localparam int unsigned DI_WIDTH    = 60;
    localparam int unsigned DO_WIDTH    = 74;
    localparam int unsigned DI_CLK_AUTO = 0;
    localparam int unsigned DI_CLK_STEP = 1;
    localparam int unsigned DI_RESET    = 2;
    localparam int unsigned DI_ADDR     = 3;
    localparam int unsigned DI_DATA     = 11;
    localparam int unsigned DI_PROG_EN  = 19;

    localparam int unsigned SNAP_BYTES      = 10;
    localparam int unsigned RST_HOLD_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARG1,
        ARG2,
        EXEC,
        RST_HOLD,
        RESP,
        SNAP_TX
    } state_t;

endpackage

// File: rtl/ppb_snap_serializer.sv
// Captures the 74-bit CPU status vector and streams it out as SNAP_BYTES bytes,
// lowest vector index in the MSB of each byte.
module ppb_snap_serializer
    import ppb_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [0:DO_WIDTH-1] snap,
    output logic [7:0]          data,
    output logic                valid,
    input  logic                ready,
    output logic                last
);

    logic [0:SNAP_BYTES*8-1] shreg;
    logic [3:0]              idx;

    assign data = shreg[0:7];
    assign last = valid && ready && (idx == 4'(SNAP_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            shreg <= {snap, {(SNAP_BYTES*8 - DO_WIDTH){1'b0}}};
            idx   <= '0;
            valid <= 1'b1;
        end else if (valid && ready) begin
            // Shift only on handshake so the presented byte holds under stall.
            if (last) begin
                valid <= 1'b0;
            end else begin
                shreg <= shreg << 8;
                idx   <= idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ppb_host_link.sv
// Byte-command host link: decodes host opcodes into CPU-board control pulses
// and returns an ACK/NAK byte or a 10-byte status snapshot.
module ppb_host_link
    import ppb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [0:DI_WIDTH-1] device_inputs,
    input  logic [0:DO_WIDTH-1] device_outputs,
    output logic                busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t     state, state_n;
    logic [7:0] op, arg_byte, resp_byte, resp_n;
    logic [7:0] prog_addr, prog_data;
    logic       run_en, ready_en, snap_load, accept, expired;
    logic [CW-1:0] tmo_cnt;
    logic [1:0]    hold_cnt;
    logic [7:0]    ser_data;
    logic          ser_valid, ser_last;

    assign rx_ready = ready_en && (state == IDLE || state == ARG1 || state == ARG2);
    assign accept   = rx_valid && rx_ready;
    assign expired  = (tmo_cnt == CW'(TIMEOUT - 1));
    assign busy     = (state != IDLE);
    assign tx_valid = (state == RESP) || (state == SNAP_TX && ser_valid);
    assign tx_data  = (state == SNAP_TX) ? ser_data : resp_byte;

    always_comb begin
        state_n = state;
        resp_n  = resp_byte;
        unique case (state)
            IDLE: if (accept) begin
                unique case (rx_data)
                    OP_STEP:  state_n = EXEC;
                    OP_RUN:   state_n = ARG1;
                    OP_RESET: state_n = RST_HOLD;
                    OP_WRITE: state_n = ARG1;
                    OP_SNAP:  state_n = SNAP_TX;
                    default: begin
                        state_n = RESP;
                        resp_n  = NAK;
                    end
                endcase
            end
            ARG1: if (accept) begin
                state_n = (op == OP_RUN) ? RESP : ARG2;
                resp_n  = ACK;
            end else if (expired) begin
                state_n = RESP;
                resp_n  = NAK;
            end
            ARG2: if (accept) begin
                state_n = EXEC;
            end else if (expired) begin
                state_n = RESP;
                resp_n  = NAK;
            end
            EXEC: begin
                state_n = RESP;
                resp_n  = ACK;
            end
            RST_HOLD: if (hold_cnt == 2'(RST_HOLD_CYCLES - 1)) begin
                state_n = RESP;
                resp_n  = ACK;
            end
            RESP:    if (tx_ready) state_n = IDLE;
            SNAP_TX: if (ser_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            arg_byte  <= '0;
            resp_byte <= '0;
            prog_addr <= '0;
            prog_data <= '0;
            run_en    <= 1'b0;
            ready_en  <= 1'b0;
            snap_load <= 1'b0;
            tmo_cnt   <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            resp_byte <= resp_n;
            ready_en  <= 1'b1;
            snap_load <= (state == IDLE) && accept && (rx_data == OP_SNAP);
            hold_cnt  <= (state == RST_HOLD) ? hold_cnt + 2'd1 : 2'd0;
            if ((state == ARG1 || state == ARG2) && !accept)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (state == IDLE && accept)
                op <= rx_data;
            if (state == ARG1 && accept) begin
                arg_byte <= rx_data;
                if (op == OP_RUN)
                    run_en <= rx_data[0];
            end
            if (state == ARG2 && accept) begin
                prog_addr <= arg_byte;
                prog_data <= rx_data;
            end
        end
    end

    // Pulses decode straight from state so they vanish with the async reset.
    always_comb begin
        device_inputs               = '0;
        device_inputs[DI_CLK_AUTO]  = run_en;
        device_inputs[DI_CLK_STEP]  = (state == EXEC) && (op == OP_STEP);
        device_inputs[DI_RESET]     = (state == RST_HOLD);
        device_inputs[DI_ADDR +: 8] = prog_addr;
        device_inputs[DI_DATA +: 8] = prog_data;
        device_inputs[DI_PROG_EN]   = (state == EXEC) && (op == OP_WRITE);
    end

    ppb_snap_serializer u_snap (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (snap_load),
        .snap  (device_outputs),
        .data  (ser_data),
        .valid (ser_valid),
        .ready (tx_ready && state == SNAP_TX),
        .last  (ser_last)
    );

endmodule

// File: tb/tb_ppb_host_link.sv
// Directed self-checking bench for ppb_host_link.
module tb_ppb_host_link;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [0:59] device_inputs;
    logic [0:73] device_outputs = '0;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int step_cnt = 0, rst_cnt = 0, pe_cnt = 0, hs_cnt = 0;
    logic [7:0] pe_addr = '0, pe_data = '0;

    ppb_host_link #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .device_inputs  (device_inputs),
        .device_outputs (device_outputs),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (device_inputs[1]) step_cnt++;
        if (device_inputs[2]) rst_cnt++;
        if (device_inputs[19]) begin
            pe_cnt++;
            pe_addr = device_inputs[3:10];
            pe_data = device_inputs[11:18];
        end
    end

    always @(posedge clk) if (tx_valid && tx_ready) hs_cnt++;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", rx_ready, 1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input int stall, output logic [7:0] b, output int n);
        tx_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 200);
        check("tx_valid_seen", tx_valid, 1);
        b = tx_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_hold", {tx_valid, tx_data}, {1'b1, b});
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1 tx_ready = 1'b0;
    endtask

    logic [7:0] b;
    logic [7:0] snap_exp [10];
    int n, base, base2, lim;

    initial begin
        #23;
        check("rst_di", device_inputs, 0);
        check("rst_tx", {tx_valid, tx_data}, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rx_ready_pre_edge", rx_ready, 0);
        @(posedge clk);
        #1 check("rx_ready_post_rst", rx_ready, 1);

        // WRITE addr 0x2A data 0x5C
        base = pe_cnt;
        send_byte(8'h10);
        #1 check("busy_arg1", busy, 1);
        send_byte(8'h2A);
        send_byte(8'h5C);
        recv_byte(0, b, n);
        check("write_ack", b, 8'hA5);
        check("write_pulse_cnt", pe_cnt - base, 1);
        check("write_pulse_addr", pe_addr, 8'h2A);
        check("write_pulse_data", pe_data, 8'h5C);
        check("write_hold_fields", {device_inputs[3:10], device_inputs[11:18], device_inputs[19]}, {8'h2A, 8'h5C, 1'b0});

        // STEP
        base = step_cnt;
        send_byte(8'h01);
        recv_byte(0, b, n);
        check("step_ack", b, 8'hA5);
        check("step_pulse_cnt", step_cnt - base, 1);

        // RESET
        base = rst_cnt;
        send_byte(8'h03);
        recv_byte(1, b, n);
        check("reset_ack", b, 8'hA5);
        check("reset_pulse_cnt", rst_cnt - base, 4);

        // RUN 1
        send_byte(8'h02);
        send_byte(8'h01);
        recv_byte(0, b, n);
        check("run_ack", b, 8'hA5);
        check("run_clk_auto", device_inputs[0], 1);

        // Unknown opcode
        send_byte(8'h7F);
        recv_byte(0, b, n);
        check("unknown_nak", b, 8'hEE);
        check("unknown_idle", busy, 0);

        // WRITE abandoned after the address byte
        base = pe_cnt;
        send_byte(8'h10);
        send_byte(8'h33);
        recv_byte(0, b, n);
        check("timeout_nak", b, 8'hEE);
        check("timeout_latency", n, 17);
        check("timeout_no_prog_en", pe_cnt - base, 0);
        check("timeout_addr_kept", device_inputs[3:10], 8'h2A);

        // RUN argument lands on the expiry cycle and must still be accepted
        send_byte(8'h02);
        repeat (15) @(negedge clk);
        send_byte(8'h00);
        recv_byte(0, b, n);
        check("expiry_byte_ack", b, 8'hA5);
        check("expiry_byte_run", device_inputs[0], 0);

        // SNAP with alternating stalls
        device_outputs          = '0;
        device_outputs[0:7]     = 8'h81;
        device_outputs[8:15]    = 8'h3C;
        device_outputs[64:71]   = 8'h5A;
        device_outputs[72:73]   = 2'b11;
        snap_exp = '{8'h81, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'hC0};
        base = hs_cnt;
        send_byte(8'h20);
        for (int i = 0; i < 10; i++) begin
            recv_byte((i % 2) * 2, b, n);
            check($sformatf("snap_byte%0d", i), b, snap_exp[i]);
        end
        repeat (5) @(negedge clk);
        check("snap_hs_cnt", hs_cnt - base, 10);
        check("snap_no_trailer", {tx_valid, busy}, 0);

        // Reset while byte 4 of a snapshot is pending
        send_byte(8'h20);
        for (int i = 0; i < 4; i++) begin
            recv_byte(0, b, n);
            check($sformatf("abort_byte%0d", i), b, snap_exp[i]);
        end
        lim = 0;
        while (!tx_valid && lim < 50) begin
            @(negedge clk);
            lim++;
        end
        check("abort_byte4_valid", {tx_valid, tx_data}, {1'b1, 8'h00});
        check("abort_pre_di", device_inputs[3:10], 8'h2A);
        #2 rst_n = 1'b0;
        #1;
        check("abort_di", device_inputs, 0);
        check("abort_tx", {tx_valid, tx_data}, 0);
        check("abort_ready_busy", {rx_ready, busy}, 0);
        base2 = hs_cnt;
        @(negedge clk) rst_n = 1'b1;
        tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_tx", hs_cnt - base2, 0);
        check("abort_tx_idle", tx_valid, 0);
        tx_ready = 1'b0;
        send_byte(8'h02);
        send_byte(8'h01);
        recv_byte(0, b, n);
        check("post_abort_ack", b, 8'hA5);
        check("post_abort_run", device_inputs[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
